// File: rtl/vga_sync_decoder.sv
// VGA timing receiver: edge-detects pixel_clk on Clk, recovers pixel X/Y from hs/vs/blank,
// measures line/frame totals and locks once a whole frame matches the expected mode.
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PixelClk,
    input  logic       Hs,
    input  logic       Vs,
    input  logic       Blank,
    output logic [9:0] RxX,
    output logic [9:0] RxY,
    output logic       RxValid,
    output logic       FrameDone,
    output logic       Locked,
    output logic [9:0] MeasHTotal,
    output logic [9:0] MeasVTotal,
    output logic [7:0] ErrCount
);
    localparam logic [9:0] HTot = 10'(H_TOTAL);
    localparam logic [9:0] VTot = 10'(V_TOTAL);
    localparam logic [9:0] HAct = 10'(H_ACTIVE);
    localparam logic [9:0] VAct = 10'(V_ACTIVE);

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == '1) ? v : v + 10'd1;
    endfunction

    logic       pclk_q, pclk_d, hs_q, hs_d, vs_q, vs_d, bad_q, bad_d;
    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, apix_q, apix_d, aline_q, aline_d;
    logic [9:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d, meas_h_q, meas_h_d, meas_v_q, meas_v_d;
    logic       rx_valid_q, rx_valid_d, frame_done_q, frame_done_d, locked_q, locked_d;
    logic [7:0] err_q, err_d;
    state_e     state_q, state_d;

    logic       tick, hs_fall, vs_fall, line_active, line_ok, bad_now, frame_ok;
    logic [9:0] line_len, pix_now, lines_now, alines_now;

    assign tick    = PixelClk & ~pclk_q;
    assign hs_fall = tick & ~Hs & hs_q;
    assign vs_fall = tick & ~Vs & vs_q;

    // Line/frame figures as they stand including the current tick, so a coincident
    // hs/vs fall closes the line into the old frame before the frame is judged.
    assign line_len    = sat_inc(hcnt_q);
    assign pix_now     = Blank ? sat_inc(apix_q) : apix_q;
    assign line_active = (pix_now != '0);
    assign line_ok     = (line_len == HTot) && (!line_active || pix_now == HAct);
    assign lines_now   = hs_fall ? sat_inc(vcnt_q) : vcnt_q;
    assign alines_now  = (hs_fall && line_active) ? sat_inc(aline_q) : aline_q;
    assign bad_now     = bad_q | (hs_fall & ~line_ok);
    assign frame_ok    = (lines_now == VTot) && (alines_now == VAct) && !bad_now;

    always_comb begin
        pclk_d       = PixelClk;
        hs_d         = hs_q;
        vs_d         = vs_q;
        bad_d        = bad_q;
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        apix_d       = apix_q;
        aline_d      = aline_q;
        rx_x_d       = rx_x_q;
        rx_y_d       = rx_y_q;
        meas_h_d     = meas_h_q;
        meas_v_d     = meas_v_q;
        rx_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        if (tick) begin
            hs_d       = Hs;
            vs_d       = Vs;
            rx_valid_d = Blank;
            hcnt_d     = sat_inc(hcnt_q);
            if (Blank) begin
                apix_d = sat_inc(apix_q);
                rx_x_d = (apix_q == '0) ? '0 : sat_inc(rx_x_q);
            end
            if (hs_fall) begin
                meas_h_d = line_len;
                hcnt_d   = '0;
                apix_d   = '0;
                vcnt_d   = lines_now;
                aline_d  = alines_now;
                bad_d    = bad_now;
                if (line_active) rx_y_d = sat_inc(rx_y_q);
            end
            if (vs_fall) begin
                frame_done_d = 1'b1;
                meas_v_d     = lines_now;
                vcnt_d       = '0;
                aline_d      = '0;
                bad_d        = 1'b0;
                rx_y_d       = '0;
            end
        end
    end

    // A failed frame while measuring is counted as well, so a persistently wrong
    // source keeps raising ErrCount instead of only the first loss of lock.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            StSearch: if (vs_fall) state_d = StMeasure;
            StMeasure: begin
                if (vs_fall) begin
                    if (frame_ok) state_d = StLocked;
                    else if (err_q != '1) err_d = err_q + 8'd1;
                end
            end
            StLocked: begin
                if ((hs_fall && !line_ok) || (vs_fall && !frame_ok)) begin
                    state_d = StSearch;
                    if (err_q != '1) err_d = err_q + 8'd1;
                end
            end
            default: state_d = StSearch;
        endcase
        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pclk_q       <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            bad_q        <= 1'b0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            apix_q       <= '0;
            aline_q      <= '0;
            rx_x_q       <= '0;
            rx_y_q       <= '0;
            meas_h_q     <= '0;
            meas_v_q     <= '0;
            rx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= '0;
            state_q      <= StSearch;
        end else begin
            pclk_q       <= pclk_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            bad_q        <= bad_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            apix_q       <= apix_d;
            aline_q      <= aline_d;
            rx_x_q       <= rx_x_d;
            rx_y_q       <= rx_y_d;
            meas_h_q     <= meas_h_d;
            meas_v_q     <= meas_v_d;
            rx_valid_q   <= rx_valid_d;
            frame_done_q <= frame_done_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            state_q      <= state_d;
        end
    end

    assign RxX        = rx_x_q;
    assign RxY        = rx_y_q;
    assign RxValid    = rx_valid_q;
    assign FrameDone  = frame_done_q;
    assign Locked     = locked_q;
    assign MeasHTotal = meas_h_q;
    assign MeasVTotal = meas_v_q;
    assign ErrCount   = err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced 10x8 mode (6x4 active) so hundreds of frames stay short.
module tb_vga_sync_decoder;
    localparam int HT = 10;
    localparam int VT = 8;
    localparam int HA = 6;
    localparam int VA = 4;

    logic       Clk, Reset, PixelClk, Hs, Vs, Blank;
    logic [9:0] RxX, RxY, MeasHTotal, MeasVTotal;
    logic       RxValid, FrameDone, Locked;
    logic [7:0] ErrCount;

    vga_sync_decoder #(
        .H_TOTAL (HT),
        .V_TOTAL (VT),
        .H_ACTIVE(HA),
        .V_ACTIVE(VA)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PixelClk  (PixelClk),
        .Hs        (Hs),
        .Vs        (Vs),
        .Blank     (Blank),
        .RxX       (RxX),
        .RxY       (RxY),
        .RxValid   (RxValid),
        .FrameDone (FrameDone),
        .Locked    (Locked),
        .MeasHTotal(MeasHTotal),
        .MeasVTotal(MeasVTotal),
        .ErrCount  (ErrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Capture state for the per-frame pixel checks.
    int cap_en, cap_nvalid, cap_nframe, cap_strobe_err;
    int cap_fx, cap_fy, cap_lx, cap_ly;
    int cur_l, cur_p, fall_l, fall_p;
    logic prev_locked;

    typedef struct {
        int nl;
        int sl;
        int reps;
        int locked;
        int err;
        int mh;
        int mv;
    } vec_t;

    vec_t vec[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {13'd0, RxX, RxY, RxValid, FrameDone, Locked, MeasHTotal, MeasVTotal, ErrCount};
    endfunction

    // One pixel: tick edge, then a non-tick edge where strobes must be low.
    task automatic pix(input logic h, input logic v, input logic b);
        @(negedge Clk);
        Hs = h;
        Vs = v;
        Blank = b;
        PixelClk = 1'b1;
        @(posedge Clk);
        #1;
        if (cap_en != 0) begin
            if (RxValid) begin
                if (cap_nvalid == 0) begin
                    cap_fx = int'(RxX);
                    cap_fy = int'(RxY);
                end
                cap_lx = int'(RxX);
                cap_ly = int'(RxY);
                cap_nvalid++;
            end
            if (FrameDone) cap_nframe++;
        end
        if (prev_locked && !Locked) begin
            fall_l = cur_l;
            fall_p = cur_p;
        end
        prev_locked = Locked;
        @(negedge Clk);
        PixelClk = 1'b0;
        @(posedge Clk);
        #1;
        if (cap_en != 0 && (RxValid || FrameDone)) cap_strobe_err++;
    endtask

    task automatic mid_reset();
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        chk("async reset outputs", outs(), 64'd0);
        #3;
        Reset = 1'b0;
    endtask

    // Frame body from l0/p1 onward, ending with the next frame's first tick (coincident
    // hs/vs fall). sl = index of a 1-tick-short line; rl/rp = where to pulse reset.
    task automatic send_frame(input int nl, input int sl, input int rl, input int rp);
        for (int l = 0; l < nl; l++) begin
            int len;
            len = (l == sl) ? HT - 1 : HT;
            for (int p = (l == 0) ? 1 : 0; p < len; p++) begin
                if (l == rl && p == rp) mid_reset();
                cur_l = l;
                cur_p = p;
                pix(p >= 2, l >= 1, p >= 3 && p < 9 && l >= 2 && l < 6);
            end
        end
        cur_l = nl;
        cur_p = 0;
        pix(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] snap;
        vec[0] = '{8, -1, 1, 1, 0, 10, 8};
        vec[1] = '{8, -1, 1, 1, 0, 10, 8};
        vec[2] = '{8, 3, 1, 0, 1, 10, 8};
        vec[3] = '{8, -1, 1, 1, 1, 10, 8};
        vec[4] = '{7, -1, 270, 0, 255, 10, 7};
        vec[5] = '{8, -1, 1, 1, 255, 10, 8};

        cap_en = 0; cap_nvalid = 0; cap_nframe = 0; cap_strobe_err = 0;
        cap_fx = -1; cap_fy = -1; cap_lx = -1; cap_ly = -1;
        cur_l = 0; cur_p = 0; fall_l = -1; fall_p = -1; prev_locked = 1'b0;
        Reset = 1'b1; PixelClk = 1'b0; Hs = 1'b1; Vs = 1'b1; Blank = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset RxX", 64'(RxX), 0);
        chk("reset RxY", 64'(RxY), 0);
        chk("reset RxValid", 64'(RxValid), 0);
        chk("reset FrameDone", 64'(FrameDone), 0);
        chk("reset Locked", 64'(Locked), 0);
        chk("reset MeasHTotal", 64'(MeasHTotal), 0);
        chk("reset MeasVTotal", 64'(MeasVTotal), 0);
        chk("reset ErrCount", 64'(ErrCount), 0);
        @(negedge Clk);
        Reset = 1'b0;

        repeat (3) pix(1'b1, 1'b1, 1'b0);
        pix(1'b0, 1'b0, 1'b0);

        // Frame-level vectors: lock, stay, short line, relock, saturate, relock.
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < vec[i].reps; r++) send_frame(vec[i].nl, vec[i].sl, -1, -1);
            chk($sformatf("vec%0d Locked", i), 64'(Locked), 64'(vec[i].locked));
            chk($sformatf("vec%0d ErrCount", i), 64'(ErrCount), 64'(vec[i].err));
            chk($sformatf("vec%0d MeasHTotal", i), 64'(MeasHTotal), 64'(vec[i].mh));
            chk($sformatf("vec%0d MeasVTotal", i), 64'(MeasVTotal), 64'(vec[i].mv));
        end

        // Locked ideal frame: pixel coordinates, strobes, coincident hs/vs close.
        cap_en = 1;
        send_frame(VT, -1, -1, -1);
        cap_en = 0;
        chk("first RxX", 64'(cap_fx), 0);
        chk("first RxY", 64'(cap_fy), 0);
        chk("last RxX", 64'(cap_lx), HA - 1);
        chk("last RxY", 64'(cap_ly), VA - 1);
        chk("visible pixel count", 64'(cap_nvalid), HA * VA);
        chk("FrameDone pulses", 64'(cap_nframe), 1);
        chk("strobes on non-tick edge", 64'(cap_strobe_err), 0);
        chk("RxY after frame close", 64'(RxY), 0);
        chk("coincident close MeasVTotal", 64'(MeasVTotal), VT);
        chk("coincident close Locked", 64'(Locked), 1);

        // Short line while locked: lock drops at the hs fall that ends it.
        send_frame(VT, 5, -1, -1);
        chk("unlock line", 64'(fall_l), 6);
        chk("unlock pixel", 64'(fall_p), 0);
        chk("unlocked after short line", 64'(Locked), 0);
        send_frame(VT, -1, -1, -1);
        chk("relock after short line", 64'(Locked), 1);

        // Static PixelClk: inputs churn but nothing may move.
        snap = outs();
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            Hs = k[0];
            Vs = k[1];
            Blank = 1'($urandom_range(0, 1));
        end
        @(posedge Clk);
        #1;
        chk("frozen without PixelClk", outs(), snap);

        // Reset mid-line, off the clock edge, then relock.
        send_frame(VT, -1, 3, 4);
        chk("after reset frame Locked", 64'(Locked), 0);
        chk("after reset frame ErrCount", 64'(ErrCount), 0);
        send_frame(VT, -1, -1, -1);
        chk("relock after reset", 64'(Locked), 1);
        chk("relock ErrCount", 64'(ErrCount), 0);
        chk("relock MeasHTotal", 64'(MeasHTotal), HT);
        chk("relock MeasVTotal", 64'(MeasVTotal), VT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
